// File: rtl/ahb3lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_pkg
//   Shared AHB-Lite bus types and constants. It provides:
//   - the transfer, burst and response encodings (HTRANS_state, HBURST_Type,
//     HRESP_state);
//   - the transfer-size and direction constants;
//   - the SRAM slave FSM state type and its default wait-state clamp.
//   The package has no ports.
// ----------------------------------------------------------------------------
package ahb3lite_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } HTRANS_state;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      WRAP4  = 3'b010,
      INCR4  = 3'b011,
      WRAP8  = 3'b100,
      INCR8  = 3'b101,
      WRAP16 = 3'b110,
      INCR16 = 3'b111
   } HBURST_Type;

   typedef enum logic {
      OKAY  = 1'b0,
      ERROR = 1'b1
   } HRESP_state;

   localparam logic [2:0] BYTE  = 3'b000;
   localparam logic [2:0] HWORD = 3'b001;
   localparam logic [2:0] WORD  = 3'b010;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   // SRAM slave FSM states
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } slave_state;

   // Default upper clamp on the per-transfer wait-state request
   localparam int SLV_MAX_WAIT = 7;

endpackage : ahb3lite_pkg

// File: rtl/ahb_sram_array.sv
// ----------------------------------------------------------------------------
// ahb_sram_array
//   A 2^ADDR_W x DATA_W word store with one synchronous write port and two
//   asynchronous read ports. One read port serves the bus and the other serves
//   the debug backdoor. The contents are never reset.
//   Ports:
//     clk_i       write clock
//     we_i        write enable
//     waddr_i     write word index
//     wdata_i     write data
//     raddr_i     bus read index
//     rdata_o     bus read data (combinational)
//     dbg_addr_i  backdoor read index
//     dbg_data_o  backdoor read data (combinational)
// ----------------------------------------------------------------------------
module ahb_sram_array #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o    = mem[raddr_i];
   assign dbg_data_o = mem[dbg_addr_i];

endmodule : ahb_sram_array

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
//   A word-addressed AHB-Lite SRAM slave. It inserts a configurable number of
//   wait states per transfer and answers illegal accesses with a two-cycle
//   ERROR response. It also checks SEQ address continuity and exposes a
//   backdoor read port and a count of write beats.
//   Ports:
//     HCLK, HRESETn        bus clock, asynchronous active-low reset
//     HSEL, HADDR, HWDATA  slave select, word address, write data
//     HWRITE, HTRANS       direction, transfer type
//     HBURST, HSIZE        burst type (sequence checker only), transfer size
//     HREADY               bus-level ready
//     HREADYOUT, HRESP     slave ready, response
//     HRDATA               read data (zero outside a read data phase)
//     i_wait_cfg           wait cycles for the next accepted transfer
//     i_dbg_addr           backdoor index
//     o_dbg_data           mem[i_dbg_addr], combinational
//     o_wr_count           completed OKAY write beats, saturating
//     o_seq_err            sticky sequence-violation flag
// ----------------------------------------------------------------------------
module ahb_sram_slave
   import ahb3lite_pkg::*;
#(
   parameter int          ADDR_W    = 6,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WAIT  = SLV_MAX_WAIT
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [31:0]       HWDATA,
   input  logic              HWRITE,
   input  HTRANS_state       HTRANS,
   input  HBURST_Type        HBURST,
   input  logic [2:0]        HSIZE,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output HRESP_state        HRESP,
   output logic [31:0]       HRDATA,
   input  logic [2:0]        i_wait_cfg,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [31:0]       o_dbg_data,
   output logic [15:0]       o_wr_count,
   output logic              o_seq_err
);

   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   slave_state        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              write_q, write_d;
   logic              ready_q;
   HRESP_state        resp_q;
   logic [15:0]       wr_count_q;
   logic              seq_err_q;
   logic [31:0]       last_addr_q;

   logic              open_slot;
   logic              accept;
   logic [31:0]       offset;
   logic              legal;
   logic [2:0]        wait_sel;
   logic              mem_we;
   logic              seq_viol;
   logic [31:0]       rd_data;

   // A new address phase is only sampled in the states that drive
   // HREADYOUT high. In S_WAIT and S_ERR1 the bus is stalled by this slave.
   assign open_slot = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign accept    = open_slot && HSEL && HREADY && ((HTRANS == NONSEQ) || (HTRANS == SEQ));

   // The 33-bit compare keeps BASE_ADDR + depth from overflowing. The top
   // address is therefore rejected rather than wrapped.
   assign offset   = HADDR - BASE_ADDR;
   assign legal    = (HSIZE == WORD) && (HADDR >= BASE_ADDR) && ({1'b0, offset} < DEPTH);
   assign wait_sel = (int'(i_wait_cfg) > MAX_WAIT) ? 3'(MAX_WAIT) : i_wait_cfg;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            // S_IDLE, S_DATA and S_ERR2 share the same accept rules.
            state_d = S_IDLE;
            if (accept) begin
               idx_d   = offset[ADDR_W-1:0];
               write_d = (HWRITE == WRITE);
               if (!legal) begin
                  state_d = S_ERR1;
               end else if (wait_sel == 3'd0) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = wait_sel;
               end
            end
         end
      endcase
   end

   // HREADYOUT and HRESP are registered from the next state. This makes them
   // glitch-free and valid from the first cycle of each state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         ready_q <= 1'b1;
         resp_q  <= OKAY;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         ready_q <= !((state_d == S_WAIT) || (state_d == S_ERR1));
         resp_q  <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? ERROR : OKAY;
      end
   end

   assign mem_we = (state_q == S_DATA) && write_q;

   // A BUSY cycle is not an accept, so it leaves last_addr_q untouched.
   assign seq_viol = accept && (HTRANS == SEQ) &&
                     ((HADDR != (last_addr_q + 32'd1)) || (HBURST == SINGLE));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_count_q  <= '0;
         seq_err_q   <= 1'b0;
         last_addr_q <= '0;
      end else begin
         if (mem_we && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
         if (seq_viol) begin
            seq_err_q <= 1'b1;
         end
         if (accept) begin
            last_addr_q <= HADDR;
         end
      end
   end

   ahb_sram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (32)
   ) u_array (
      .clk_i      (HCLK),
      .we_i       (mem_we),
      .waddr_i    (idx_q),
      .wdata_i    (HWDATA),
      .raddr_i    (idx_q),
      .rdata_o    (rd_data),
      .dbg_addr_i (i_dbg_addr),
      .dbg_data_o (o_dbg_data)
   );

   assign HREADYOUT  = ready_q;
   assign HRESP      = resp_q;
   assign HRDATA     = ((state_q == S_DATA) && !write_q) ? rd_data : 32'h0;
   assign o_wr_count = wr_count_q;
   assign o_seq_err  = seq_err_q;

endmodule : ahb_sram_slave

// File: tb/tb_ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave
//   A directed testbench for ahb_sram_slave. There is a single slave on the
//   bus, so HREADY is looped back from HREADYOUT. Inputs change 1 ns after
//   the rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave;
   import ahb3lite_pkg::*;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HWRITE;
   HTRANS_state HTRANS;
   HBURST_Type  HBURST;
   logic [2:0]  HSIZE;
   logic        HREADYOUT;
   HRESP_state  HRESP;
   logic [31:0] HRDATA;
   logic [2:0]  i_wait_cfg;
   logic [5:0]  i_dbg_addr;
   logic [31:0] o_dbg_data;
   logic [15:0] o_wr_count;
   logic        o_seq_err;

   int checks   = 0;
   int failures = 0;

   // Phase tables for zero-wait write sequences
   HTRANS_state tr_v [16];
   logic [31:0] ad_v [16];
   logic [31:0] dt_v [16];

   ahb_sram_slave #(
      .ADDR_W    (6),
      .BASE_ADDR (32'h0000_0000),
      .MAX_WAIT  (7)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL       (HSEL),
      .HADDR      (HADDR),
      .HWDATA     (HWDATA),
      .HWRITE     (HWRITE),
      .HTRANS     (HTRANS),
      .HBURST     (HBURST),
      .HSIZE      (HSIZE),
      .HREADY     (HREADYOUT),
      .HREADYOUT  (HREADYOUT),
      .HRESP      (HRESP),
      .HRDATA     (HRDATA),
      .i_wait_cfg (i_wait_cfg),
      .i_dbg_addr (i_dbg_addr),
      .o_dbg_data (o_dbg_data),
      .o_wr_count (o_wr_count),
      .o_seq_err  (o_seq_err)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic mem_chk(input logic [5:0] a, input logic [31:0] exp, input string tag);
      i_dbg_addr = a;
      #1;
      check(tag, o_dbg_data, exp);
   endtask

   // Drives n zero-wait address phases from the tables and then one IDLE.
   // Each phase's data is driven in the following cycle. HREADYOUT must
   // stay high and HRESP must stay OKAY throughout.
   task automatic run_phases(input int n, input HBURST_Type b, input string tag);
      logic [31:0] pend;
      logic        pend_v;
      pend       = 32'h0;
      pend_v     = 1'b0;
      HSEL       = 1'b1;
      HWRITE     = 1'b1;
      HSIZE      = WORD;
      HBURST     = b;
      i_wait_cfg = 3'd0;
      for (int i = 0; i <= n; i++) begin
         HWDATA = pend_v ? pend : 32'h0;
         if (i < n) begin
            HTRANS = tr_v[i];
            HADDR  = ad_v[i];
            pend_v = (tr_v[i] == NONSEQ) || (tr_v[i] == SEQ);
            pend   = dt_v[i];
         end else begin
            HTRANS = IDLE;
            pend_v = 1'b0;
         end
         tick();
         check($sformatf("%s ready[%0d]", tag, i), {31'b0, HREADYOUT}, 32'h1);
         check($sformatf("%s resp[%0d]", tag, i), {31'b0, HRESP}, 32'h0);
      end
   endtask

   initial begin : stim
      int low_cnt;

      HRESETn    = 1'b0;
      HSEL       = 1'b0;
      HADDR      = 32'h0;
      HWDATA     = 32'h0;
      HWRITE     = 1'b0;
      HTRANS     = IDLE;
      HBURST     = SINGLE;
      HSIZE      = WORD;
      i_wait_cfg = 3'd0;
      i_dbg_addr = 6'd0;

      // Reset values
      repeat (2) @(posedge HCLK);
      #1;
      check("rst ready", {31'b0, HREADYOUT}, 32'h1);
      check("rst resp", {31'b0, HRESP}, 32'h0);
      check("rst rdata", HRDATA, 32'h0);
      check("rst wr_count", {16'b0, o_wr_count}, 32'h0);
      check("rst seq_err", {31'b0, o_seq_err}, 32'h0);
      HRESETn = 1'b1;
      tick();

      // SINGLE write to word 0, used later as the alias target of 0x40
      tr_v[0] = NONSEQ; ad_v[0] = 32'h00; dt_v[0] = 32'h5A5A_0000;
      run_phases(1, SINGLE, "w0");
      mem_chk(6'h00, 32'h5A5A_0000, "w0 mem[0]");
      check("w0 wr_count", {16'b0, o_wr_count}, 32'd1);

      // INCR4 zero-wait write at 0x10
      for (int i = 0; i < 4; i++) begin
         tr_v[i] = (i == 0) ? NONSEQ : SEQ;
         ad_v[i] = 32'h10 + 32'(i);
         dt_v[i] = 32'hA0 + 32'(i);
      end
      run_phases(4, INCR4, "incr4");
      for (int i = 0; i < 4; i++) begin
         mem_chk(6'(16 + i), 32'hA0 + 32'(i), $sformatf("incr4 mem[%0h]", 16 + i));
      end
      check("incr4 wr_count", {16'b0, o_wr_count}, 32'd5);

      // SINGLE write to 0x05 with three wait states
      HSEL = 1'b1; HWRITE = 1'b1; HSIZE = WORD; HBURST = SINGLE;
      HTRANS = NONSEQ; HADDR = 32'h05; i_wait_cfg = 3'd3;
      tick();
      HTRANS = IDLE; HWDATA = 32'h0000_0555; i_wait_cfg = 3'd0;
      low_cnt = 0;
      for (int c = 0; c < 20 && !HREADYOUT; c++) begin
         check("w5 resp in wait", {31'b0, HRESP}, 32'h0);
         low_cnt++;
         tick();
      end
      check("w5 wait cycles", 32'(low_cnt), 32'd3);
      check("w5 ready after wait", {31'b0, HREADYOUT}, 32'h1);
      tick();
      mem_chk(6'h05, 32'h0000_0555, "w5 mem[5]");
      check("w5 wr_count", {16'b0, o_wr_count}, 32'd6);

      // Out-of-range write to 0x40 gets a two-cycle ERROR and no write
      HTRANS = NONSEQ; HADDR = 32'h40; HWRITE = 1'b1;
      tick();
      check("err c1 ready", {31'b0, HREADYOUT}, 32'h0);
      check("err c1 resp", {31'b0, HRESP}, 32'h1);
      HTRANS = IDLE; HWDATA = 32'hBAD0_BAD0;
      tick();
      check("err c2 ready", {31'b0, HREADYOUT}, 32'h1);
      check("err c2 resp", {31'b0, HRESP}, 32'h1);
      tick();
      check("err after resp", {31'b0, HRESP}, 32'h0);
      check("err wr_count", {16'b0, o_wr_count}, 32'd6);
      mem_chk(6'h00, 32'h5A5A_0000, "err mem[0] intact");

      // Zero-wait read of 0x11
      HTRANS = NONSEQ; HADDR = 32'h11; HWRITE = 1'b0;
      tick();
      HTRANS = IDLE;
      check("rd0 rdata", HRDATA, 32'hA1);
      tick();
      check("rd0 rdata idle", HRDATA, 32'h0);

      // Read of 0x12 with two wait states: HRDATA is zero while waiting
      HTRANS = NONSEQ; HADDR = 32'h12; i_wait_cfg = 3'd2;
      tick();
      HTRANS = IDLE; i_wait_cfg = 3'd0;
      check("rd2 wait1 ready", {31'b0, HREADYOUT}, 32'h0);
      check("rd2 wait1 rdata", HRDATA, 32'h0);
      tick();
      check("rd2 wait2 ready", {31'b0, HREADYOUT}, 32'h0);
      tick();
      check("rd2 data ready", {31'b0, HREADYOUT}, 32'h1);
      check("rd2 rdata", HRDATA, 32'hA2);
      tick();
      check("rd2 rdata idle", HRDATA, 32'h0);

      // INCR8 at 0x20 with two BUSY cycles after the third beat
      for (int i = 0; i < 10; i++) begin
         int beat;
         beat = (i < 3) ? i : ((i < 5) ? 3 : i - 2);
         tr_v[i] = (i == 0) ? NONSEQ : (((i == 3) || (i == 4)) ? BUSY : SEQ);
         ad_v[i] = 32'h20 + 32'(beat);
         dt_v[i] = 32'hB0 + 32'(beat);
      end
      run_phases(10, INCR8, "incr8");
      for (int i = 0; i < 8; i++) begin
         mem_chk(6'(32 + i), 32'hB0 + 32'(i), $sformatf("incr8 mem[%0h]", 32 + i));
      end
      check("incr8 seq_err", {31'b0, o_seq_err}, 32'h0);
      check("incr8 wr_count", {16'b0, o_wr_count}, 32'd14);

      // SEQ beat that jumps 0x12 -> 0x15 sets the sticky error flag
      tr_v[0] = NONSEQ; ad_v[0] = 32'h12; dt_v[0] = 32'hC0;
      tr_v[1] = SEQ;    ad_v[1] = 32'h15; dt_v[1] = 32'hC1;
      run_phases(2, INCR4, "jump");
      check("jump seq_err", {31'b0, o_seq_err}, 32'h1);
      mem_chk(6'h15, 32'hC1, "jump mem[15]");
      mem_chk(6'h12, 32'hC0, "jump mem[12]");
      tick();
      tick();
      check("jump seq_err sticky", {31'b0, o_seq_err}, 32'h1);
      check("jump wr_count", {16'b0, o_wr_count}, 32'd16);

      // Reset asserted during the wait of a write to 0x08
      tr_v[0] = NONSEQ; ad_v[0] = 32'h08; dt_v[0] = 32'h0808_0808;
      run_phases(1, SINGLE, "w8");
      mem_chk(6'h08, 32'h0808_0808, "w8 mem[8]");
      HTRANS = NONSEQ; HADDR = 32'h08; HWRITE = 1'b1; i_wait_cfg = 3'd4;
      tick();
      HTRANS = IDLE; HWDATA = 32'hDEAD_BEEF; i_wait_cfg = 3'd0;
      check("rstw in wait", {31'b0, HREADYOUT}, 32'h0);
      tick();
      #2;
      HRESETn = 1'b0;
      #1;
      check("rstw ready", {31'b0, HREADYOUT}, 32'h1);
      check("rstw resp", {31'b0, HRESP}, 32'h0);
      check("rstw rdata", HRDATA, 32'h0);
      check("rstw wr_count", {16'b0, o_wr_count}, 32'h0);
      check("rstw seq_err", {31'b0, o_seq_err}, 32'h0);
      tick();
      tick();
      HRESETn = 1'b1;
      HSEL    = 1'b0;
      tick();
      tick();
      tick();
      tick();
      mem_chk(6'h08, 32'h0808_0808, "rstw mem[8] kept");
      check("rstw wr_count after", {16'b0, o_wr_count}, 32'h0);
      check("rstw ready after", {31'b0, HREADYOUT}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ahb_sram_slave
